inert_sensor_resp: RTL and testbench

//  SPI responder (slave) for the inertial-sensor bus that inert_intf masters.

---
 rtl/inert_sensor_resp.sv | 212 +++++++++++++++++++++
 tb/tb_inert_sensor_resp.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/inert_sensor_resp.sv
// inert_sensor_resp
//   SPI responder standing in for the inertial sensor on the inert_intf bus.
//   Decodes 16-bit mode-0 frames (bit15 = read, [14:8] = address,
//   [7:0] = write data). It serves a small register map with WHO_AM_I,
//   INT_CTRL and pitch/roll/yaw snapshots. INT rises when a fresh snapshot
//   is available.
//
// Ports
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset
//   SS_n     in   SPI slave select, active low, asynchronous to clk
//   SCLK     in   SPI clock, mode 0, idle low, asynchronous to clk
//   MOSI     in   SPI data from master, MSB first
//   MISO     out  SPI data to master, high-impedance while SS_n is high
//   INT      out  data-ready interrupt, active high
//   ptch_in  in   pitch rate source, captured at snapshot
//   roll_in  in   roll rate source, captured at snapshot
//   yaw_in   in   yaw rate source, captured at snapshot
//
// Handshake: there is no valid/ready pair. A frame is bracketed by SS_n low.
// The master changes MOSI while SCLK is low. Both sides sample on the SCLK
// rise. The SCLK half-period must be at least 4 clk cycles so that the
// synchronised edges settle between SPI edges.
module inert_sensor_resp #(
    parameter int          INT_PERIOD = 65536,
    parameter logic [7:0]  WHO_AM_I   = 8'h6A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        INT,
    input  logic [15:0] ptch_in,
    input  logic [15:0] roll_in,
    input  logic [15:0] yaw_in
);

    localparam int                CNT_W   = $clog2(INT_PERIOD);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(INT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    // Synchroniser chains. They are deliberately left unreset so that they
    // always reflect the real pins, including right after reset. A reset
    // taken mid-frame therefore cannot fabricate an SS_n fall.
    logic ss_s1, ss_s2;
    logic sclk_s1, sclk_s2, sclk_s3;
    logic mosi_s1, mosi_s2;

    always_ff @(posedge clk) begin
        ss_s1   <= SS_n;
        ss_s2   <= ss_s1;
        sclk_s1 <= SCLK;
        sclk_s2 <= sclk_s1;
        sclk_s3 <= sclk_s2;
        mosi_s1 <= MOSI;
        mosi_s2 <= mosi_s1;
    end

    // ss_prev resets low. A frame therefore only starts after SS_n has been
    // seen high since reset.
    logic ss_prev;
    logic ss_fall, sclk_rise, sclk_fall;

    assign ss_fall   = ss_prev & ~ss_s2;
    assign sclk_rise = sclk_s2 & ~sclk_s3;
    assign sclk_fall = ~sclk_s2 & sclk_s3;

    state_t      state, state_nxt;
    logic [4:0]  bit_cnt;
    logic [14:0] rx;
    logic [15:0] rx_nxt;
    logic [7:0]  tx_byte;
    logic        frame_rise, byte_done, frame_done;
    logic        miso_bit;

    // Rises after the 16th are ignored.
    assign frame_rise = sclk_rise && (state != IDLE) && (bit_cnt != 5'd16);
    assign byte_done  = frame_rise && (bit_cnt == 5'd7);
    assign frame_done = frame_rise && (bit_cnt == 5'd15);
    assign rx_nxt     = {rx, mosi_s2};

    // Frame FSM: state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            ss_prev <= 1'b0;
        end else begin
            state   <= state_nxt;
            ss_prev <= ss_s2;
        end
    end

    // Frame FSM: next state. Deselect returns to IDLE from anywhere.
    always_comb begin
        state_nxt = state;
        if (ss_s2) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (ss_fall)    state_nxt = CMD;
                CMD:     if (byte_done)  state_nxt = DATA;
                DATA:    if (frame_done) state_nxt = DONE;
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Frame FSM: outputs. The command byte is answered with zeros.
    always_comb begin
        miso_bit = 1'b0;
        if (state == DATA || state == DONE) miso_bit = tx_byte[7];
    end

    assign MISO = SS_n ? 1'bz : miso_bit;

    // Registers.
    logic             int_en;
    logic             pending;
    logic [CNT_W-1:0] period_cnt;
    logic [15:0]      ptch_q, roll_q, yaw_q;
    logic [7:0]       rd_data;
    logic             wr_en, wr_dis, rd_clr, snap_take, wrap;

    // Read mux. It is indexed by the address that has just completed at the
    // 8th rise.
    always_comb begin
        rd_data = 8'h00;
        case (rx_nxt[6:0])
            7'h0F:   rd_data = WHO_AM_I;
            7'h0D:   rd_data = {7'b0, int_en};
            7'h22:   rd_data = ptch_q[7:0];
            7'h23:   rd_data = ptch_q[15:8];
            7'h24:   rd_data = roll_q[7:0];
            7'h25:   rd_data = roll_q[15:8];
            7'h26:   rd_data = yaw_q[7:0];
            7'h27:   rd_data = yaw_q[15:8];
            default: rd_data = 8'h00;
        endcase
    end

    // Bit counter, receive shifter and transmit shifter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt <= 5'd0;
            rx      <= 15'd0;
            tx_byte <= 8'h00;
        end else begin
            if (state == IDLE) begin
                bit_cnt <= 5'd0;
            end else if (frame_rise) begin
                bit_cnt <= bit_cnt + 5'd1;
                rx      <= rx_nxt[14:0];
            end
            if (byte_done) begin
                tx_byte <= rd_data;
            end else if (sclk_fall && state != IDLE &&
                         bit_cnt >= 5'd9 && bit_cnt <= 5'd15) begin
                // The fall right after the 8th rise must keep bit 7 on the
                // line for the master's 9th sample, so shifting starts one
                // fall later.
                tx_byte <= {tx_byte[6:0], 1'b0};
            end
        end
    end

    // A write commits only on a complete frame. Only INT_CTRL is writable.
    assign wr_en     = frame_done && !rx_nxt[15] && (rx_nxt[14:8] == 7'h0D);
    assign wr_dis    = wr_en && !rx_nxt[0];
    assign rd_clr    = frame_done && rx_nxt[15] && (rx_nxt[14:8] == 7'h27);
    assign wrap      = int_en && (period_cnt == CNT_MAX);
    // Snapshots wait for IDLE so that a burst of byte reads sees one
    // coherent sample.
    assign snap_take = pending && (state == IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            int_en     <= 1'b0;
            pending    <= 1'b0;
            period_cnt <= '0;
            ptch_q     <= 16'h0000;
            roll_q     <= 16'h0000;
            yaw_q      <= 16'h0000;
            INT        <= 1'b0;
        end else begin
            if (wr_en) int_en <= rx_nxt[0];

            if (!int_en || wrap) period_cnt <= '0;
            else                 period_cnt <= period_cnt + 1'b1;

            if (wr_dis)         pending <= 1'b0;
            else if (wrap)      pending <= 1'b1;
            else if (snap_take) pending <= 1'b0;

            if (snap_take) begin
                ptch_q <= ptch_in;
                roll_q <= roll_in;
                yaw_q  <= yaw_in;
            end

            // A snapshot taken in the same cycle as a yaw-high read keeps
            // INT set.
            if (wr_dis)         INT <= 1'b0;
            else if (snap_take) INT <= 1'b1;
            else if (rd_clr)    INT <= 1'b0;
        end
    end

endmodule

// File: tb/tb_inert_sensor_resp.sv
`timescale 1ns/1ps
module tb_inert_sensor_resp;

  localparam int INT_PERIOD = 2048;
  localparam int HALF       = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ss_n = 1'b1;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  wire         miso;
  logic        intr;
  logic [15:0] ptch_in = 16'h0000;
  logic [15:0] roll_in = 16'h0000;
  logic [15:0] yaw_in  = 16'h0000;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] exp_q[$];

  inert_sensor_resp #(.INT_PERIOD(INT_PERIOD), .WHO_AM_I(8'h6A)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .SS_n    (ss_n),
    .SCLK    (sclk),
    .MOSI    (mosi),
    .MISO    (miso),
    .INT     (intr),
    .ptch_in (ptch_in),
    .roll_in (roll_in),
    .yaw_in  (yaw_in)
  );

  // clock / cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // driver: one SPI frame of nbits; rst_at pulses reset while SCLK is high
  // on that rise
  task automatic spi_frame(input logic [15:0] word, input int nbits, input int rst_at);
    @(negedge clk);
    ss_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = word[15-i];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      if (rst_at != 0 && i + 1 == rst_at) begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
      end
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    ss_n = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic read_frame(input logic [15:0] word, input logic [7:0] exp_byte);
    exp_q.push_back({8'h00, exp_byte});
    spi_frame(word, 16, 0);
  endtask

  task automatic wait_int(input logic level, input int budget, input string name);
    int n;
    n = 0;
    while (intr !== level && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {15'b0, intr}, {15'b0, level});
  endtask

  // scoreboard monitor: collects MISO on each SCLK rise of a frame; a
  // complete 16-bit frame pops one expectation
  task automatic monitor_loop();
    int          cnt;
    logic [15:0] word;
    forever begin
      @(negedge ss_n);
      cnt  = 0;
      word = 16'h0000;
      forever begin
        @(posedge sclk or posedge ss_n);
        if (ss_n) break;
        if (cnt < 16) word = {word[14:0], miso};
        cnt++;
      end
      if (cnt == 16) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL miso_frame got %h expected <none queued>", word);
        end else begin
          check("miso_frame", word, exp_q.pop_front());
        end
      end
    end
  endtask

  initial begin
    int t_int, t_int2, t_rise, tgt;
    fork
      monitor_loop();
    join_none

    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_int", {15'b0, intr}, 16'h0000);

    // WHO_AM_I after reset
    read_frame(16'h8F00, 8'h6A);
    check("int_idle", {15'b0, intr}, 16'h0000);

    // enable INT, wait for first snapshot, read all data bytes
    ptch_in = 16'h1234;
    roll_in = 16'hABCD;
    yaw_in  = 16'h00FF;
    read_frame(16'h0D01, 8'h00);
    check("int_not_early", {15'b0, intr}, 16'h0000);
    wait_int(1'b1, INT_PERIOD + 8, "int_set");
    t_int = cyc;
    read_frame(16'hA200, 8'h34);
    read_frame(16'hA300, 8'h12);
    read_frame(16'hA400, 8'hCD);
    read_frame(16'hA500, 8'hAB);
    read_frame(16'hA600, 8'hFF);
    check("int_held", {15'b0, intr}, 16'h0001);
    read_frame(16'hA700, 8'h00);
    check("int_cleared", {15'b0, intr}, 16'h0000);

    // next INT exactly one period after the previous one
    wait_int(1'b1, INT_PERIOD + 8, "int_again");
    t_int2 = cyc;
    check("int_period", 16'(t_int2 - t_int), 16'(INT_PERIOD));

    // wrap falls inside a read frame: that frame returns old data
    ptch_in = 16'h5678;
    roll_in = 16'h9ABC;
    yaw_in  = 16'hDEF0;
    read_frame(16'hA700, 8'h00);
    check("int_cleared2", {15'b0, intr}, 16'h0000);
    tgt = t_int2 + INT_PERIOD - 100;
    while (cyc < tgt) @(negedge clk);
    read_frame(16'hA200, 8'h34);
    wait_int(1'b1, 20, "int_after_frame");
    t_rise = cyc;
    check("int_deferred", {15'b0, (t_rise - t_int2) > INT_PERIOD + 50}, 16'h0001);
    read_frame(16'hA200, 8'h78);
    read_frame(16'hA300, 8'h56);
    read_frame(16'hA700, 8'hDE);

    // disable, aborted write, read-only and unmapped addresses
    read_frame(16'h0D00, 8'h01);
    check("int_disabled", {15'b0, intr}, 16'h0000);
    spi_frame(16'h0D01, 10, 0);
    read_frame(16'h8D00, 8'h00);
    repeat (INT_PERIOD + 20) @(negedge clk);
    check("no_int_after_abort", {15'b0, intr}, 16'h0000);
    read_frame(16'h0F55, 8'h6A);
    read_frame(16'h8F00, 8'h6A);
    read_frame(16'hFF00, 8'h00);

    // reset in the middle of a write to INT_CTRL
    read_frame(16'h0D01, 8'h00);
    wait_int(1'b1, INT_PERIOD + 8, "int_before_reset");
    exp_q.push_back(16'h0000);
    spi_frame(16'h0D01, 16, 6);
    check("int_after_reset", {15'b0, intr}, 16'h0000);
    read_frame(16'h8D00, 8'h00);
    read_frame(16'h8F00, 8'h6A);
    repeat (INT_PERIOD + 20) @(negedge clk);
    check("no_int_after_reset", {15'b0, intr}, 16'h0000);

    check("queue_drained", 16'(exp_q.size()), 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
